// File: rtl/tetris_pkg.sv
// Shared piece definitions: shape codes, key codes, game-state code and base cell sizes.
package tetris_pkg;

  typedef enum logic [2:0] {
    SHAPE_I = 3'd0,
    SHAPE_O = 3'd1,
    SHAPE_T = 3'd2,
    SHAPE_S = 3'd3,
    SHAPE_Z = 3'd4,
    SHAPE_J = 3'd5,
    SHAPE_L = 3'd6
  } shape_e;

  localparam logic [2:0] KEY_NONE   = 3'd0;
  localparam logic [2:0] KEY_LEFT   = 3'd1;
  localparam logic [2:0] KEY_RIGHT  = 3'd2;
  localparam logic [2:0] KEY_DOWN   = 3'd3;
  localparam logic [2:0] KEY_ROTATE = 3'd4;
  localparam logic [2:0] KEY_HOLD   = 3'd5;

  localparam logic [1:0] GS_PLAY = 2'd1;

  // Index 7 is never a legal shape; it is padded so every 3-bit index is in range.
  localparam logic [2:0] BASE_CELLS_X [0:7] = '{3'd4, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3};
  localparam logic [2:0] BASE_CELLS_Y [0:7] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};

  // First bag candidate of a draw: the low three LFSR bits, with code 7 folded onto I.
  function automatic logic [2:0] firstCandidate(input logic [15:0] lfsrValue);
    logic [2:0] low;
    low = lfsrValue[2:0];
    return (low == 3'd7) ? 3'd0 : low;
  endfunction

endpackage

// File: rtl/piece_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16/14/13/11) used as the bag randomizer source.
module piece_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        i_enable,
  output logic [15:0] o_value
);

  logic [15:0] r_lfsr;
  logic        w_feedback;

  assign w_feedback = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign o_value    = r_lfsr;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_lfsr <= SEED;
    end else if (i_enable) begin
      r_lfsr <= {r_lfsr[14:0], w_feedback};
    end
  end

endmodule

// File: rtl/piece_generator.sv
// Active/next piece source: 7-bag draws, rotation tracking and pixel sizes for the datapath.
// Optional hold slot is enabled by defining PIECE_HOLD_EN.
module piece_generator
  import tetris_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          CELL_PX   = 20
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       reset_game,
  input  logic [1:0] gamestate,
  input  logic [2:0] keypress,
  input  logic       ResetShape,
  input  logic       rot_inhibit,
  output logic [2:0] shape_num,
  output logic [1:0] shape_rot,
  output logic [9:0] shape_size_x,
  output logic [9:0] shape_size_y,
  output logic [2:0] next_shape,
  output logic       piece_valid
`ifdef PIECE_HOLD_EN
  ,
  output logic [2:0] held_shape
`endif
);

  typedef enum logic [1:0] {
    ST_FILL_CUR,
    ST_FILL_NXT,
    ST_READY,
    ST_ADVANCE
  } gen_state_e;

  gen_state_e  r_state;
  logic [6:0]  r_bagMask;
  logic        r_searching;
  logic [2:0]  r_cand;
  logic [2:0]  r_shapeNum;
  logic [1:0]  r_shapeRot;
  logic [2:0]  r_nextShape;
  logic        r_valid;
  logic        r_rotPrev;

  logic [15:0] w_lfsr;
  logic [2:0]  w_cand;
  logic [2:0]  w_candNext;
  logic        w_candFree;
  logic [6:0]  w_maskSet;
  logic [6:0]  w_maskAfter;
  logic        w_rotOk;
  logic [2:0]  w_baseX;
  logic [2:0]  w_baseY;
  logic [2:0]  w_cellsX;
  logic [2:0]  w_cellsY;

  piece_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_enable(1'b1),
    .o_value (w_lfsr)
  );

  // A draw checks its candidate in the same cycle it is formed, so a free first pick costs one cycle.
  assign w_cand      = r_searching ? r_cand : firstCandidate(w_lfsr);
  assign w_candFree  = ~r_bagMask[w_cand];
  assign w_candNext  = (w_cand == 3'd6) ? 3'd0 : w_cand + 3'd1;
  assign w_maskSet   = r_bagMask | (7'd1 << w_cand);
  assign w_maskAfter = (w_maskSet == 7'h7F) ? 7'd0 : w_maskSet;

  assign w_rotOk = (keypress == KEY_ROTATE) && !r_rotPrev && (gamestate == GS_PLAY) &&
                   !rot_inhibit && (r_shapeNum != SHAPE_O);

`ifdef PIECE_HOLD_EN
  logic [2:0] r_hold;
  logic       r_holdFull;
  logic       r_holdUsed;
  logic       r_holdPrev;
  logic       w_holdOk;

  assign w_holdOk   = (keypress == KEY_HOLD) && !r_holdPrev && (gamestate == GS_PLAY) && !r_holdUsed;
  assign held_shape = r_hold;
`endif

  always_ff @(posedge Clk) begin
    if (Reset || reset_game) begin
      r_state     <= ST_FILL_CUR;
      r_bagMask   <= 7'd0;
      r_searching <= 1'b0;
      r_cand      <= 3'd0;
      r_shapeNum  <= 3'd0;
      r_shapeRot  <= 2'd0;
      r_nextShape <= 3'd0;
      r_valid     <= 1'b0;
      r_rotPrev   <= 1'b0;
`ifdef PIECE_HOLD_EN
      r_hold      <= 3'd0;
      r_holdFull  <= 1'b0;
      r_holdUsed  <= 1'b0;
      r_holdPrev  <= 1'b0;
`endif
    end else begin
      r_rotPrev <= (keypress == KEY_ROTATE);
`ifdef PIECE_HOLD_EN
      r_holdPrev <= (keypress == KEY_HOLD);
`endif
      case (r_state)
        ST_FILL_CUR, ST_FILL_NXT, ST_ADVANCE: begin
          if (w_candFree) begin
            r_bagMask   <= w_maskAfter;
            r_searching <= 1'b0;
            if (r_state == ST_FILL_CUR) begin
              r_shapeNum <= w_cand;
              r_state    <= ST_FILL_NXT;
            end else begin
              r_nextShape <= w_cand;
              r_valid     <= 1'b1;
              r_state     <= ST_READY;
            end
          end else begin
            r_cand      <= w_candNext;
            r_searching <= 1'b1;
          end
        end
        ST_READY: begin
          // A landing always beats a same-cycle rotate or hold request.
          if (ResetShape) begin
            r_shapeNum <= r_nextShape;
            r_shapeRot <= 2'd0;
            r_valid    <= 1'b0;
            r_state    <= ST_ADVANCE;
`ifdef PIECE_HOLD_EN
            r_holdUsed <= 1'b0;
`endif
          end else if (w_rotOk) begin
            r_shapeRot <= r_shapeRot + 2'd1;
`ifdef PIECE_HOLD_EN
          end else if (w_holdOk) begin
            r_holdUsed <= 1'b1;
            r_hold     <= r_shapeNum;
            r_shapeRot <= 2'd0;
            if (!r_holdFull) begin
              r_holdFull <= 1'b1;
              r_shapeNum <= r_nextShape;
              r_valid    <= 1'b0;
              r_state    <= ST_ADVANCE;
            end else begin
              r_shapeNum <= r_hold;
            end
`endif
          end
        end
        default: r_state <= ST_FILL_CUR;
      endcase
    end
  end

  assign w_baseX  = BASE_CELLS_X[r_shapeNum];
  assign w_baseY  = BASE_CELLS_Y[r_shapeNum];
  assign w_cellsX = r_shapeRot[0] ? w_baseY : w_baseX;
  assign w_cellsY = r_shapeRot[0] ? w_baseX : w_baseY;

  assign shape_size_x = 10'(w_cellsX * CELL_PX);
  assign shape_size_y = 10'(w_cellsY * CELL_PX);
  assign shape_num    = r_shapeNum;
  assign shape_rot    = r_shapeRot;
  assign next_shape   = r_nextShape;
  assign piece_valid  = r_valid;

endmodule

// File: tb/tb_piece_generator.sv
// Self-checking bench for piece_generator: cycle-level reference model plus bag permutation checks.
// Covers the hold slot when compiled with PIECE_HOLD_EN.
module tb_piece_generator;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int CELL = 20;
  localparam int PH_FILL_CUR = 0, PH_FILL_NXT = 1, PH_READY = 2, PH_ADVANCE = 3;

  logic       Clk = 1'b0;
  logic       Reset, reset_game, ResetShape, rot_inhibit;
  logic [1:0] gamestate;
  logic [2:0] keypress;
  logic [2:0] shape_num, next_shape;
  logic [1:0] shape_rot;
  logic [9:0] shape_size_x, shape_size_y;
  logic       piece_valid;
`ifdef PIECE_HOLD_EN
  logic [2:0] held_shape;
`endif

  int nChecks = 0;
  int nErrors = 0;

  piece_generator #(
    .LFSR_SEED(SEED),
    .CELL_PX  (CELL)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .reset_game  (reset_game),
    .gamestate   (gamestate),
    .keypress    (keypress),
    .ResetShape  (ResetShape),
    .rot_inhibit (rot_inhibit),
    .shape_num   (shape_num),
    .shape_rot   (shape_rot),
    .shape_size_x(shape_size_x),
    .shape_size_y(shape_size_y),
    .next_shape  (next_shape),
    .piece_valid (piece_valid)
`ifdef PIECE_HOLD_EN
    ,
    .held_shape  (held_shape)
`endif
  );

  always #5 Clk = ~Clk;

  // Reference model state, expressed in terms of the game rules.
  logic [15:0] mLfsr;
  bit          used [7];
  int          mPhase, mShape, mRot, mNext, mHold;
  bit          mValid, mPrevRot, mPrevHold, mHoldFull, mHoldUsed;
  int          drawLeft, drawRes;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nErrors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < 7; i++) used[i] = 0;
    mPhase = PH_FILL_CUR; mShape = 0; mRot = 0; mNext = 0; mValid = 0;
    mPrevRot = 0; mPrevHold = 0; mHold = 0; mHoldFull = 0; mHoldUsed = 0;
    drawLeft = -1; drawRes = 0;
  endtask

  task automatic modelDraw(input logic [15:0] cur);
    int c;
    bit full;
    if (drawLeft < 0) begin
      c = int'(cur[2:0]);
      if (c == 7) c = 0;
      drawLeft = 0;
      while (drawLeft < 7 && used[(c + drawLeft) % 7]) drawLeft++;
      drawRes = (c + drawLeft) % 7;
    end
    if (drawLeft == 0) begin
      used[drawRes] = 1;
      full = 1;
      for (int i = 0; i < 7; i++) full &= used[i];
      if (full) for (int i = 0; i < 7; i++) used[i] = 0;
      if (mPhase == PH_FILL_CUR) begin
        mShape = drawRes;
        mPhase = PH_FILL_NXT;
      end else begin
        mNext  = drawRes;
        mValid = 1;
        mPhase = PH_READY;
      end
      drawLeft = -1;
    end else begin
      drawLeft--;
    end
  endtask

  task automatic modelStep();
    logic [15:0] cur;
    bit rotEdge, holdEdge;
    int tmp;
    if (Reset) begin
      mLfsr = SEED;
      modelClear();
      return;
    end
    cur = mLfsr;
    mLfsr = {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    if (reset_game) begin
      modelClear();
      return;
    end
    rotEdge  = (keypress == 3'd4) && !mPrevRot;
    holdEdge = (keypress == 3'd5) && !mPrevHold;
    mPrevRot  = (keypress == 3'd4);
    mPrevHold = (keypress == 3'd5);
    if (mPhase == PH_READY) begin
      if (ResetShape) begin
        mShape = mNext; mRot = 0; mValid = 0; mPhase = PH_ADVANCE; mHoldUsed = 0;
      end else if (rotEdge && gamestate == 2'd1 && !rot_inhibit && mShape != 1) begin
        mRot = (mRot + 1) % 4;
      end
`ifdef PIECE_HOLD_EN
      else if (holdEdge && gamestate == 2'd1 && !mHoldUsed) begin
        mHoldUsed = 1; mRot = 0;
        if (!mHoldFull) begin
          mHold = mShape; mHoldFull = 1; mShape = mNext; mValid = 0; mPhase = PH_ADVANCE;
        end else begin
          tmp = mShape; mShape = mHold; mHold = tmp;
        end
      end
`else
      if (holdEdge) tmp = 0;
`endif
    end else begin
      modelDraw(cur);
    end
  endtask

  task automatic expectedSize(input int s, input int r, output int x, output int y);
    int cx, cy, t;
    case (s)
      0:       begin cx = 4; cy = 1; end
      1:       begin cx = 2; cy = 2; end
      default: begin cx = 3; cy = 2; end
    endcase
    if (r % 2 == 1) begin t = cx; cx = cy; cy = t; end
    x = (cx * CELL) % 1024;
    y = (cy * CELL) % 1024;
  endtask

  // One clock: advance the model with the current inputs, then compare every output at the falling edge.
  task automatic stepCycle();
    int ex, ey;
    modelStep();
    @(posedge Clk);
    @(negedge Clk);
    expectedSize(mShape, mRot, ex, ey);
    checkOutput("shape_num", 16'(shape_num), 16'(mShape));
    checkOutput("shape_rot", 16'(shape_rot), 16'(mRot));
    checkOutput("next_shape", 16'(next_shape), 16'(mNext));
    checkOutput("piece_valid", 16'(piece_valid), 16'(mValid));
    checkOutput("shape_size_x", 16'(shape_size_x), 16'(ex));
    checkOutput("shape_size_y", 16'(shape_size_y), 16'(ey));
`ifdef PIECE_HOLD_EN
    checkOutput("held_shape", 16'(held_shape), 16'(mHold));
`endif
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic applyStimulus(input logic [2:0] key, input int cycles);
    keypress = key;
    runCycles(cycles);
  endtask

  task automatic pulseResetShape();
    ResetShape = 1'b1;
    stepCycle();
    ResetShape = 1'b0;
  endtask

  task automatic randomCycles(input int n, input int maxKey);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) keypress = 3'($urandom_range(0, maxKey));
      rot_inhibit = ($urandom_range(0, 4) == 0);
      gamestate   = ($urandom_range(0, 6) == 0) ? 2'd2 : 2'd1;
      stepCycle();
    end
    keypress = 3'd0; rot_inhibit = 1'b0; gamestate = 2'd1;
  endtask

  task automatic advanceUntil(input int target);
    for (int i = 0; i < 16 && mShape != target; i++) begin
      pulseResetShape();
      runCycles(9);
    end
  endtask

  task automatic checkBag(input string tag, input int pieces[$], input int first);
    logic [6:0] seen;
    seen = 7'd0;
    for (int i = first; i < first + 7; i++)
      if (pieces[i] < 7) seen[pieces[i]] = 1'b1;
    checkOutput(tag, 16'(seen), 16'h007F);
  endtask

  initial begin
    int pieces[$];
    Reset = 1'b1; reset_game = 1'b0; ResetShape = 1'b0; rot_inhibit = 1'b0;
    gamestate = 2'd1; keypress = 3'd0;
    runCycles(3);
    Reset = 1'b0;

    runCycles(16);
    checkOutput("valid_after_reset", 16'(piece_valid), 16'd1);
    checkOutput("cur_differs_next", 16'(shape_num != next_shape), 16'd1);

    pieces.push_back(int'(shape_num));
    for (int k = 0; k < 14; k++) begin
      randomCycles($urandom_range(9, 12), 4);
      pulseResetShape();
      pieces.push_back(int'(shape_num));
    end
    runCycles(9);
    checkBag("bag_pieces_1_7", pieces, 0);
    checkBag("bag_pieces_8_14", pieces, 7);

    $display("[TB] directed rotation on I and O");
    advanceUntil(0);
    applyStimulus(3'd4, 3);
    applyStimulus(3'd0, 2);
    applyStimulus(3'd4, 1);
    applyStimulus(3'd0, 2);
    rot_inhibit = 1'b1;
    applyStimulus(3'd4, 2);
    applyStimulus(3'd0, 1);
    rot_inhibit = 1'b0;
    gamestate = 2'd2;
    applyStimulus(3'd4, 2);
    applyStimulus(3'd0, 1);
    gamestate = 2'd1;
    advanceUntil(1);
    applyStimulus(3'd4, 2);
    applyStimulus(3'd0, 2);

    // Rotate and landing in the same cycle; the held key must not rotate later.
    runCycles(9);
    keypress = 3'd4;
    pulseResetShape();
    runCycles(12);
    keypress = 3'd0;
    runCycles(2);

    $display("[TB] restart during advance and during fill");
    pulseResetShape();
    reset_game = 1'b1;
    stepCycle();
    reset_game = 1'b0;
    runCycles(16);
    checkOutput("valid_after_restart", 16'(piece_valid), 16'd1);
    checkOutput("restart_cur_differs", 16'(shape_num != next_shape), 16'd1);
    reset_game = 1'b1;
    stepCycle();
    reset_game = 1'b0;
    stepCycle();
    reset_game = 1'b1;
    stepCycle();
    reset_game = 1'b0;
    runCycles(16);

`ifdef PIECE_HOLD_EN
    $display("[TB] hold slot sequence");
    applyStimulus(3'd5, 2);
    applyStimulus(3'd0, 10);
    applyStimulus(3'd5, 2);
    applyStimulus(3'd0, 2);
    pulseResetShape();
    runCycles(9);
    applyStimulus(3'd4, 1);
    applyStimulus(3'd5, 2);
    applyStimulus(3'd0, 4);
`endif

    for (int k = 0; k < 10; k++) begin
      randomCycles($urandom_range(9, 20), 5);
      pulseResetShape();
    end
    runCycles(10);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/piece_generator.md
Name: piece_generator

Overview:
- Upstream feeder of the datapath's falling-block logic. Supplies shape_num, shape_rot, shape_size_x and shape_size_y for the active piece.
- Draws new pieces from a 7-bag randomizer driven by a free-running LFSR. Holds a one-deep next-piece preview for the colour mapper.
- Tracks rotation from the player's rotate key and advances to the next piece on the datapath's ResetShape pulse.

Parameters:
- LFSR_SEED, 16'hACE1, non-zero reset value of the LFSR.
- CELL_PX, 20, pixel edge of one cell; shape sizes are cell counts times CELL_PX.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous active-high reset
- reset_game  in  1  synchronous restart; same effect as Reset except the LFSR keeps running
- gamestate  in  2  2'd1 = playing; all other codes freeze rotation and hold
- keypress  in  3  0 none, 1 left, 2 right, 3 down, 4 rotate, 5 hold
- ResetShape  in  1  one-cycle pulse: active piece landed, load the next one
- rot_inhibit  in  1  rotation would collide; ignore the rotate press
- shape_num  out  3  active piece: 0 I, 1 O, 2 T, 3 S, 4 Z, 5 J, 6 L
- shape_rot  out  2  active rotation, 0..3
- shape_size_x  out  10  active piece width in pixels
- shape_size_y  out  10  active piece height in pixels
- next_shape  out  3  preview piece
- piece_valid  out  1  high when shape outputs are stable and usable

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous, active-high, and named Reset as elsewhere in the datapath.
- Reset values:
  - shape_num 0, shape_rot 0, next_shape 0, piece_valid 0.
  - bag mask 0, LFSR = LFSR_SEED.
  - FSM enters FILL_CUR.
- LFSR:
  - 16-bit Fibonacci, taps 16/14/13/11, shifts every cycle in every state.
- FSM states: FILL_CUR, FILL_NXT, READY, ADVANCE.
  - FILL_CUR and FILL_NXT each run one draw. Draw result goes to shape_num or next_shape respectively.
  - FILL_CUR → FILL_NXT → READY. piece_valid rises on entry to READY.
  - In READY, a ResetShape pulse copies next_shape into shape_num, clears shape_rot, drops piece_valid and enters ADVANCE.
  - ADVANCE runs one draw into next_shape, then returns to READY.
- Draw procedure:
  - Cycle 0: candidate c = lfsr[2:0]; code 7 maps to 0.
  - Each following cycle, while bag_mask[c] is set, c = (c+1) mod 7.
  - When an unused c is found: accept it, set bag_mask[c].
  - If the mask becomes 7'h7F, clear it in the same cycle.
  - A draw takes at most 7 cycles, so any ResetShape-to-valid latency is at most 8 cycles.
- ResetShape outside READY is ignored; the datapath never issues it sooner than 8 cycles apart.
- Rotation:
  - Rising edge of (keypress==4) in READY, gamestate==1 and rot_inhibit==0 sets shape_rot = shape_rot+1, wrapping 3→0.
  - A held key rotates once.
  - The O piece stays at rot 0.
- Sizes, combinational from the registered shape_num/shape_rot:
  - Cell dims at rot 0: I 4x1, O 2x2, all others 3x2.
  - Odd rotations swap x and y.
  - Size = cells × CELL_PX, truncated to 10 bits.
- reset_game, mid-draw or in any state: restart from FILL_CUR with mask cleared. Edge-detect register is cleared.
- Simultaneous rotate and ResetShape: ResetShape wins; rotation is discarded.

Optional Feature:
- Macro PIECE_HOLD_EN.
- When defined:
  - Adds a hold register (3 bits) and a hold_valid flag; adds output held_shape[2:0].
  - A rising edge of keypress==5 in READY with gamestate==1 does one of two things:
    - Hold empty: move shape_num into hold, then take the ADVANCE path.
    - Hold full: swap shape_num with hold and clear shape_rot.
  - Hold is allowed once per piece; it re-arms on the next ResetShape.
  - Reset and reset_game empty the hold register.
- When undefined: keypress 5 is ignored and held_shape is absent.

Decomposition:
- Package tetris_pkg holds:
  - the shape_e enum (I..L);
  - the keypress code constants;
  - the GS_PLAY constant;
  - the per-shape base cell-size table.
- One natural sub-module, piece_lfsr: the LFSR with seed parameter, a restart-free enable, and a 16-bit output.

Test Plan:
- Reset with LFSR_SEED=16'hACE1, run 3 cycles → piece_valid=1 within 16 cycles; shape_num ≠ next_shape.
- 14 ResetShape pulses spaced 10 cycles apart → each consecutive group of 7 shape_num values (pieces 1-7, 8-14) is a permutation of 0..6.
- shape_num=0 (I), rotate pressed 3 cycles then released → shape_rot=1 once; sizes 20x80. A second press gives rot 2 and sizes 80x20.
- Rotate with rot_inhibit=1, or gamestate=2 → shape_rot unchanged. O piece with rotate → rot stays 0, sizes 40x40.
- Assert reset_game during ADVANCE → piece_valid=0 next cycle; mask cleared; new valid pieces within 16 cycles.
- With PIECE_HOLD_EN: hold on T (shape 2) → held_shape=2 and shape_num = previous next_shape. A second hold before ResetShape is ignored; hold after ResetShape swaps.
